// File: rtl/block_write_scheduler.sv
// block_write_scheduler: buffers window samples and writes them, zero pad and tag words into
// block RAM through a single-outstanding AXI4 write channel.
module block_write_scheduler #(
   parameter int DATA_WIDTH = 256,
   parameter int BLOCK_DEPTH = 400,
   parameter int BLOCK_DEPTH_INDEX = 9,
   parameter int BLOCK_NUM_INDEX = 4,
   parameter int FIFO_DEPTH_INDEX = 2,
   parameter logic [127:0] TAG_SEQUENCE = 128'h00_01_02_03_04_05_06_07_08_09_00_01_02_03_04_05
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic                       close,
   output logic                       block_done,
   output logic [BLOCK_NUM_INDEX-1:0] block_done_no,
   output logic                       wr_err,
   output logic [31:0]                m_axi_awaddr,
   output logic                       m_axi_awvalid,
   input  logic                       m_axi_awready,
   output logic [3:0]                 m_axi_awid,
   output logic [7:0]                 m_axi_awlen,
   output logic [2:0]                 m_axi_awsize,
   output logic [1:0]                 m_axi_awburst,
   output logic [DATA_WIDTH-1:0]      m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]    m_axi_wstrb,
   output logic                       m_axi_wlast,
   output logic                       m_axi_wvalid,
   input  logic                       m_axi_wready,
   input  logic [1:0]                 m_axi_bresp,
   input  logic                       m_axi_bvalid,
   output logic                       m_axi_bready
);
   localparam int FIFO_DEPTH = 2 ** FIFO_DEPTH_INDEX;
   typedef enum logic [1:0] {FILL, PAD, TAG} mode_t;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;
   logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
   logic [FIFO_DEPTH_INDEX-1:0] rd_ptr_q, wr_ptr_q;
   logic [FIFO_DEPTH_INDEX:0] count_q, count_d;
   mode_t mode_q;
   wstate_t wst_q;
   logic [BLOCK_DEPTH_INDEX-1:0] word_ptr_q;
   logic [BLOCK_NUM_INDEX-1:0] block_no_q, block_done_no_q;
   logic close_pending_q, awvalid_q, wvalid_q, block_done_q, wr_err_q;
   logic [31:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic push, pop, fifo_empty, issue, drop_close, last_data;
   logic [3:0] tag_idx;
   logic [7:0] tag_byte;
   assign m_axi_awaddr = awaddr_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awid = 4'd0;
   assign m_axi_awlen = 8'd0;
   assign m_axi_awsize = 3'b101;
   assign m_axi_awburst = 2'b01;
   assign m_axi_wdata = wdata_q;
   assign m_axi_wstrb = '1;
   assign m_axi_wlast = 1'b1;
   assign m_axi_wvalid = wvalid_q;
   assign m_axi_bready = 1'b1;
   assign block_done = block_done_q;
   assign block_done_no = block_done_no_q;
   assign wr_err = wr_err_q;
   always_comb begin
      fifo_empty = count_q == '0;
      wr_ready = !rst && !count_q[FIFO_DEPTH_INDEX] && mode_q == FILL && !close_pending_q;
      push = wr_valid && wr_ready;
      issue = wst_q == W_IDLE && (mode_q != FILL || !fifo_empty);
      pop = issue && mode_q == FILL;
      count_d = count_q + (FIFO_DEPTH_INDEX+1)'(push) - (FIFO_DEPTH_INDEX+1)'(pop);
      // a close with nothing written to the current block and nothing queued is a no-op
      drop_close = wst_q == W_IDLE && mode_q == FILL && fifo_empty && word_ptr_q == '0;
      last_data = word_ptr_q == BLOCK_DEPTH_INDEX'(BLOCK_DEPTH - 2);
      tag_idx = 4'(block_no_q);
      tag_byte = TAG_SEQUENCE[8*(15 - int'(tag_idx)) +: 8];
      wdata_d = mode_q == FILL ? fifo_q[rd_ptr_q] : mode_q == PAD ? '0 : DATA_WIDTH'(tag_byte);
   end
   always_ff @(posedge clk)
      if (push) fifo_q[wr_ptr_q] <= wr_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q <= '0;
         mode_q <= FILL;
         wst_q <= W_IDLE;
         word_ptr_q <= '0;
         block_no_q <= '0;
         block_done_no_q <= '0;
         close_pending_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q <= 1'b0;
         block_done_q <= 1'b0;
         wr_err_q <= 1'b0;
         awaddr_q <= '0;
         wdata_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_INDEX'(push);
         rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_INDEX'(pop);
         count_q <= count_d;
         block_done_q <= 1'b0;
         if (close && mode_q == FILL && !(drop_close && !push)) close_pending_q <= 1'b1;
         case (wst_q)
            W_IDLE:
               if (issue) begin
                  awvalid_q <= 1'b1;
                  wvalid_q <= 1'b1;
                  awaddr_q <= 32'({block_no_q, word_ptr_q, 5'b0});
                  wdata_q <= wdata_d;
                  wst_q <= W_SEND;
               end else if (mode_q == FILL && close_pending_q) begin
                  close_pending_q <= 1'b0;
                  if (word_ptr_q != '0) mode_q <= PAD;
               end
            W_SEND: begin
               awvalid_q <= awvalid_q && !m_axi_awready;
               wvalid_q <= wvalid_q && !m_axi_wready;
               if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) wst_q <= W_RESP;
            end
            W_RESP:
               if (m_axi_bvalid) begin
                  wst_q <= W_IDLE;
                  if (m_axi_bresp != 2'b00) wr_err_q <= 1'b1;
                  if (mode_q == TAG) begin
                     block_no_q <= block_no_q + BLOCK_NUM_INDEX'(1);
                     word_ptr_q <= '0;
                     mode_q <= FILL;
                     block_done_q <= 1'b1;
                     block_done_no_q <= block_no_q;
                  end else begin
                     word_ptr_q <= word_ptr_q + BLOCK_DEPTH_INDEX'(1);
                     if (last_data) mode_q <= TAG;
                  end
               end
            default: wst_q <= W_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_block_write_scheduler.sv
// tb_block_write_scheduler: scoreboard bench with a reactive AXI slave, small block depth.
module tb_block_write_scheduler;
   localparam int BD = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic [255:0] wr_data;
   logic wr_valid, wr_ready, close, block_done, wr_err;
   logic [3:0] block_done_no, m_axi_awid;
   logic [31:0] m_axi_awaddr, m_axi_wstrb;
   logic m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
   logic [7:0] m_axi_awlen;
   logic [2:0] m_axi_awsize;
   logic [1:0] m_axi_awburst, m_axi_bresp;
   logic [255:0] m_axi_wdata;
   always #5 clk = ~clk;
   block_write_scheduler #(.DATA_WIDTH(256), .BLOCK_DEPTH(BD), .BLOCK_DEPTH_INDEX(2),
      .BLOCK_NUM_INDEX(4), .FIFO_DEPTH_INDEX(2)) dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .close(close), .block_done(block_done), .block_done_no(block_done_no), .wr_err(wr_err),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready));
   int vectors = 0, miscompares = 0;
   logic [31:0] exp_addr_q[$];
   logic [255:0] exp_data_q[$];
   int blk_q[$];
   int m_blk = 0, m_word = 0, aw_stall = 0, err_at = -1, wcount = 0;
   logic [31:0] got_addr;
   logic [255:0] got_data;
   logic aw_got = 0, w_got = 0, aw_seen = 0;
   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // expected writes: data at {block, word}; the tag follows word BD-2
   task automatic push_word(input logic [255:0] d);
      exp_addr_q.push_back(32'(((m_blk % 16) << 7) | (m_word << 5)));
      exp_data_q.push_back(d);
      m_word++;
      if (m_word == BD - 1) begin
         exp_addr_q.push_back(32'(((m_blk % 16) << 7) | ((BD - 1) << 5)));
         exp_data_q.push_back(256'((m_blk % 16) % 10));
         blk_q.push_back(m_blk % 16);
         m_blk++;
         m_word = 0;
      end
   endtask
   task automatic close_model();
      while (m_word != 0) push_word('0);
   endtask
   task automatic send(input logic [255:0] d, input logic cl);
      int n = 0;
      wr_data = d;
      wr_valid = 1'b1;
      close = cl;
      while (!wr_ready && n < 100) begin
         @(negedge clk);
         close = 1'b0;
         n++;
      end
      if (n == 100) check("send_timeout", 0, 1);
      else push_word(d);
      @(negedge clk);
      close = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while ((exp_addr_q.size() != 0 || blk_q.size() != 0 || m_axi_awvalid || m_axi_wvalid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n == 3000) check("drain_timeout", 0, 1);
      repeat (3) @(negedge clk);
   endtask
   initial begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            aw_got = 0; w_got = 0; aw_seen = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            continue;
         end
         if (m_axi_bvalid) m_axi_bvalid = 1'b0;
         else if (aw_got && w_got) begin
            check("one_out", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
            wcount++;
            m_axi_bresp = wcount == err_at ? 2'b10 : 2'b00;
            if (exp_addr_q.size() == 0) check("sb_empty", 1, 0);
            else begin
               check("addr", got_addr, exp_addr_q.pop_front());
               check("data", got_data, exp_data_q.pop_front());
            end
            aw_got = 0; w_got = 0;
            m_axi_bvalid = 1'b1;
         end
         m_axi_awready = 0;
         m_axi_wready = 0;
         if (m_axi_awvalid && !aw_got) begin
            if (aw_seen) check("aw_stable", m_axi_awaddr, got_addr);
            else begin
               got_addr = m_axi_awaddr;
               aw_seen = 1;
            end
            if (aw_stall > 0) aw_stall--;
            else begin
               m_axi_awready = 1; aw_got = 1; aw_seen = 0;
            end
         end
         if (m_axi_wvalid && !w_got) begin
            got_data = m_axi_wdata;
            m_axi_wready = 1;
            w_got = 1;
         end
      end
   end
   initial forever begin
      @(negedge clk);
      if (!rst && block_done) begin
         if (blk_q.size() == 0) check("done_extra", 1, 0);
         else check("done_no", block_done_no, blk_q.pop_front());
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int idle_aw, rdy_low;
      wr_valid = 0; close = 0; wr_data = '0;
      repeat (3) @(negedge clk);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_awvalid", m_axi_awvalid, 0);
      check("rst_wvalid", m_axi_wvalid, 0);
      check("rst_done", block_done, 0);
      check("rst_done_no", block_done_no, 0);
      check("rst_wr_err", wr_err, 0);
      check("bready", m_axi_bready, 1);
      check("wstrb", m_axi_wstrb, 32'hFFFF_FFFF);
      check("aw_const", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wlast}, {4'd0, 8'd0, 3'b101, 2'b01, 1'b1});
      rst = 0;
      @(negedge clk);
      check("rdy_after_rst", wr_ready, 1);
      send({8{32'hAAAA_0001}}, 0);
      send({8{32'hBBBB_0002}}, 0);
      send({8{32'hCCCC_0003}}, 0);
      wr_valid = 0;
      drain();
      send({8{32'hDDDD_0004}}, 0);
      wr_valid = 0;
      close = 1;
      close_model();
      @(negedge clk);
      close = 0;
      drain();
      send({8{32'hEEEE_0005}}, 1);
      wr_valid = 0;
      close_model();
      drain();
      close = 1;
      @(negedge clk);
      close = 0;
      idle_aw = 0; rdy_low = 0;
      repeat (20) begin
         idle_aw += int'(m_axi_awvalid);
         rdy_low += int'(!wr_ready);
         @(negedge clk);
      end
      check("close_empty_aw", idle_aw, 0);
      check("close_empty_rdy", rdy_low, 0);
      aw_stall = 5;
      for (int i = 0; i < 5; i++) send({8{32'h5700_0000 + 32'(i)}}, 0);
      wr_valid = 0;
      check("stall_full", wr_ready, 0);
      check("stall_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
      drain();
      close = 1;
      close_model();
      @(negedge clk);
      close = 0;
      drain();
      check("err_before", wr_err, 0);
      err_at = wcount + 2;
      for (int i = 0; i < 3; i++) send({8{32'hE550_0000 + 32'(i)}}, 0);
      wr_valid = 0;
      drain();
      check("err_set", wr_err, 1);
      for (int i = 0; i < 3; i++) send({8{32'hF000_0000 + 32'(i)}}, 0);
      wr_valid = 0;
      drain();
      check("err_sticky", wr_err, 1);
      send({8{32'h1234_5678}}, 0);
      wr_valid = 0;
      for (int n = 0; n < 50 && !m_axi_awvalid; n++) @(negedge clk);
      rst = 1;
      @(negedge clk);
      check("midrst_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
      check("midrst_rdy", wr_ready, 0);
      check("midrst_done_no", block_done_no, 0);
      check("midrst_err", wr_err, 0);
      @(negedge clk);
      exp_addr_q.delete(); exp_data_q.delete(); blk_q.delete();
      m_blk = 0; m_word = 0; err_at = -1;
      rst = 0;
      @(negedge clk);
      check("rdy_after_midrst", wr_ready, 1);
      for (int i = 0; i < 17 * (BD - 1); i++) send({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()}, 0);
      wr_valid = 0;
      drain();
      check("wrap_err", wr_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
